// File: rtl/dda_sequencer.sv
// Run-control sequencer for the posit Van der Pol DDA core: decodes SPI command
// words, holds mu/icx/icy, paces load/step pulses and captures {x,y} snapshots.
module dda_sequencer #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  input  logic [31:0]    cmd_word,
  input  logic [N-1:0]   dda_x,
  input  logic [N-1:0]   dda_y,
  output logic           dda_step,
  output logic           dda_load,
  output logic [N-1:0]   mu,
  output logic [N-1:0]   icx,
  output logic [N-1:0]   icy,
  output logic [2*N-1:0] snap,
  output logic           snap_valid,
  output logic           running,
  output logic [15:0]    step_count
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_SET_MU = 4'd1, OP_SET_ICX = 4'd2, OP_SET_ICY = 4'd3,
    OP_SET_DIV = 4'd4, OP_RUN = 4'd5, OP_HALT = 4'd6, OP_LOAD = 4'd7, OP_SNAP = 4'd8
  } opcode_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mu_q, mu_d, icx_q, icx_d, icy_q, icy_d;
  logic [15:0]    div_q, div_d, rem_q, rem_d, presc_q, presc_d, cnt_q, cnt_d;
  logic           free_q, free_d, step_q, step_d, load_q, load_d;
  logic           snap_valid_q, snap_valid_d, pend_q, pend_d;
  logic [2*N-1:0] snap_q, snap_d;
  logic           fire;

  logic [3:0]  opcode;
  logic [15:0] payload;
  logic        unused_bits;
  assign opcode      = cmd_word[31:28];
  assign payload     = cmd_word[15:0];
  assign unused_bits = ^cmd_word[27:16];

  always_comb begin
    state_d      = state_q;
    mu_d         = mu_q;
    icx_d        = icx_q;
    icy_d        = icy_q;
    div_d        = div_q;
    rem_d        = rem_q;
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    free_d       = free_q;
    snap_d       = snap_q;
    step_d       = 1'b0;
    load_d       = 1'b0;
    snap_valid_d = 1'b0;
    pend_d       = 1'b0;
    fire         = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (cmd_valid && opcode == OP_HALT) begin
          state_d = S_IDLE;
        end else if (!free_q && rem_q == 16'd0) begin
          // final step is on the bus this cycle; sample its result next edge
          state_d = S_IDLE;
          pend_d  = 1'b1;
        end else if (presc_q == 16'd0) begin
          fire    = 1'b1;
          presc_d = div_q - 16'd1;
        end else begin
          presc_d = presc_q - 16'd1;
        end
      end
      default: begin
        if (cmd_valid && opcode == OP_RUN) begin
          state_d = S_RUN;
          free_d  = (payload == 16'd0);
          rem_d   = payload;
          // the RUN edge itself counts as one prescaler tick so the first
          // step lands exactly div cycles after the command
          if (div_q == 16'd1) begin
            fire    = 1'b1;
            presc_d = 16'd0;
          end else begin
            presc_d = div_q - 16'd2;
          end
        end else if (cmd_valid && opcode == OP_LOAD) begin
          load_d = 1'b1;
          cnt_d  = 16'd0;
        end
      end
    endcase

    if (fire) begin
      step_d = 1'b1;
      cnt_d  = cnt_q + 16'd1;
      if (!free_d) rem_d = rem_d - 16'd1;
    end

    if ((cmd_valid && opcode == OP_SNAP) || pend_q) begin
      snap_d       = {dda_x, dda_y};
      snap_valid_d = 1'b1;
    end

    if (cmd_valid) begin
      unique case (opcode)
        OP_SET_MU:  mu_d  = payload[N-1:0];
        OP_SET_ICX: icx_d = payload[N-1:0];
        OP_SET_ICY: icy_d = payload[N-1:0];
        OP_SET_DIV: div_d = (payload == 16'd0) ? 16'd1 : payload;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mu_q         <= '0;
      icx_q        <= N'(16'h3000);
      icy_q        <= N'(16'h3000);
      div_q        <= 16'd1;
      rem_q        <= 16'd0;
      presc_q      <= 16'd0;
      cnt_q        <= 16'd0;
      free_q       <= 1'b0;
      snap_q       <= '0;
      step_q       <= 1'b0;
      load_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mu_q         <= mu_d;
      icx_q        <= icx_d;
      icy_q        <= icy_d;
      div_q        <= div_d;
      rem_q        <= rem_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      free_q       <= free_d;
      snap_q       <= snap_d;
      step_q       <= step_d;
      load_q       <= load_d;
      snap_valid_q <= snap_valid_d;
      pend_q       <= pend_d;
    end
  end

  assign dda_step   = step_q;
  assign dda_load   = load_q;
  assign mu         = mu_q;
  assign icx        = icx_q;
  assign icy        = icy_q;
  assign snap       = snap_q;
  assign snap_valid = snap_valid_q;
  assign running    = (state_q == S_RUN);
  assign step_count = cnt_q;

endmodule
